// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared register file widths and reg_dump_ctrl state encoding
package cpu_defs;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [2:0] {
    DUMP_IDLE  = 3'd0,
    DUMP_DRAIN = 3'd1,
    DUMP_FETCH = 3'd2,
    DUMP_VALID = 3'd3,
    DUMP_DONE  = 3'd4
  } dump_state_t;

endpackage

// File: rtl/drain_timer.sv
// rtl/drain_timer.sv - loadable down-counter with zero flag for the pipeline drain wait
module drain_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; the counter saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - halts the CPU and streams a register file snapshot; REG_DUMP_SKIP_ZERO_EN drops zero-valued entries
module reg_dump_ctrl
  import cpu_defs::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  cpu_halt,
  output logic [REG_ADDR_W-1:0] rd_reg,
  input  logic [REG_DATA_W-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_DATA_W-1:0] out_data,
  output logic [REG_ADDR_W-1:0] out_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = 16;
  localparam logic [REG_ADDR_W-1:0] FIRST_IDX  = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX   = REG_ADDR_W'(LAST_REG);
  localparam logic [CNT_W-1:0]      DRAIN_LOAD = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;
  localparam bit                    SKIP_DRAIN = (DRAIN_CYCLES == 0);

  dump_state_t           state_q;
  logic [REG_ADDR_W-1:0] idx_q;
  logic [REG_ADDR_W-1:0] rd_reg_q;
  logic [REG_DATA_W-1:0] out_data_q;
  logic [REG_ADDR_W-1:0] out_idx_q;
  logic                  out_valid_q;
  logic                  cpu_halt_q;
  logic                  busy_q;
  logic                  done_q;

  logic [REG_ADDR_W-1:0] idx_d;
  logic                  idx_last;
  logic                  start_ok;
  logic                  timer_load;
  logic                  timer_dec;
  logic                  drain_zero;

  assign idx_d      = idx_q + 1'b1;
  assign idx_last   = (idx_q == LAST_IDX);
  assign start_ok   = (state_q == DUMP_IDLE) && start && !abort;
  assign timer_load = start_ok;
  assign timer_dec  = (state_q == DUMP_DRAIN);

  drain_timer #(
    .W(CNT_W)
  ) u_drain_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (DRAIN_LOAD),
    .dec_i      (timer_dec),
    .zero_o     (drain_zero)
  );

  // Dump sequencer; abort from any active state returns to IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DUMP_IDLE;
      idx_q       <= '0;
      rd_reg_q    <= FIRST_IDX;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      cpu_halt_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort && (state_q != DUMP_IDLE)) begin
      state_q     <= DUMP_IDLE;
      out_valid_q <= 1'b0;
      cpu_halt_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DUMP_IDLE: begin
          if (start_ok) begin
            cpu_halt_q <= 1'b1;
            busy_q     <= 1'b1;
            idx_q      <= FIRST_IDX;
            rd_reg_q   <= FIRST_IDX;
            state_q    <= SKIP_DRAIN ? DUMP_FETCH : DUMP_DRAIN;
          end
        end
        DUMP_DRAIN: begin
          if (drain_zero) begin
            state_q <= DUMP_FETCH;
          end
        end
        DUMP_FETCH: begin
`ifdef REG_DUMP_SKIP_ZERO_EN
          if (rd_data == '0) begin
            if (idx_last) begin
              done_q  <= 1'b1;
              state_q <= DUMP_DONE;
            end else begin
              idx_q    <= idx_d;
              rd_reg_q <= idx_d;
            end
          end else begin
            out_data_q  <= rd_data;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= DUMP_VALID;
          end
`else
          out_data_q  <= rd_data;
          out_idx_q   <= idx_q;
          out_valid_q <= 1'b1;
          state_q     <= DUMP_VALID;
`endif
        end
        DUMP_VALID: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_last) begin
              done_q  <= 1'b1;
              state_q <= DUMP_DONE;
            end else begin
              idx_q    <= idx_d;
              rd_reg_q <= idx_d;
              state_q  <= DUMP_FETCH;
            end
          end
        end
        DUMP_DONE: begin
          cpu_halt_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= DUMP_IDLE;
        end
        default: begin
          state_q     <= DUMP_IDLE;
          out_valid_q <= 1'b0;
          cpu_halt_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_halt  = cpu_halt_q;
  assign rd_reg    = rd_reg_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - self-checking bench for reg_dump_ctrl
module tb_reg_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        cpu_halt;
  logic [4:0]  rd_reg;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  logic [4:0]  got_idx[$];
  logic [31:0] got_data[$];
  logic [4:0]  exp_idx[$];
  logic [31:0] exp_data[$];
  int first_valid_cyc;
  int done_cyc;
  int done_count;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        halt;
    logic        valid;
    logic        done;
    logic [4:0]  idx;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[15];

  always #5 clk = ~clk;

  assign rd_data = regs[rd_reg];

  reg_dump_ctrl #(
    .DRAIN_CYCLES(4),
    .FIRST_REG   (0),
    .LAST_REG    (31)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cpu_halt (cpu_halt),
    .rd_reg   (rd_reg),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic a, input logic r, input logic b,
                              input logic h, input logic v, input logic d,
                              input logic [4:0] ix, input logic [31:0] dat);
    vec_t t;
    t.start = s; t.abort = a; t.ready = r; t.busy = b; t.halt = h;
    t.valid = v; t.done = d; t.idx = ix; t.data = dat;
    return t;
  endfunction

  task automatic load_regs(input int step, input int off);
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * step + off);
  endtask

  // Reference: every register in order, zero entries dropped when skipping is built in.
  function automatic void build_expected();
    exp_idx.delete();
    exp_data.delete();
    for (int i = 0; i < 32; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
      if (regs[i] == 32'd0) continue;
`endif
      exp_idx.push_back(5'(i));
      exp_data.push_back(regs[i]);
    end
  endfunction

  task automatic run_dump(input string name, input int ready_mode, input bit extra_start, input bit wb_write);
    int cyc;
    bit finished;
    bit pv, pr;
    logic [31:0] pd;
    logic [4:0] pi;
    got_idx.delete();
    got_data.delete();
    done_count = 0;
    first_valid_cyc = -1;
    done_cyc = -1;
    cyc = 0;
    finished = 0;
    start = 1'b1;
    out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    while (!finished && cyc < 400) begin
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx;
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk($sformatf("%s_halt_rise", name), cpu_halt, 1);
      if (pv && pr) begin
        got_idx.push_back(pi);
        got_data.push_back(pd);
      end
      if (pv && !pr) begin
        chk($sformatf("%s_hold_valid", name), out_valid, 1);
        chk($sformatf("%s_hold_data", name), out_data, pd);
        chk($sformatf("%s_hold_idx", name), out_idx, pi);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_count++;
        done_cyc = cyc;
        chk($sformatf("%s_halt_at_done", name), cpu_halt, 1);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk($sformatf("%s_halt_fall", name), cpu_halt, 0);
        chk($sformatf("%s_busy_end", name), busy, 0);
        finished = 1;
      end
      if (extra_start && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (wb_write && cyc == 2) begin
        @(negedge clk);
        regs[5] = 32'hDEADBEEF;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk($sformatf("%s_finished", name), 32'(finished), 1);
  endtask

  task automatic compare_dump(input string name);
    build_expected();
    chk($sformatf("%s_nwords", name), 32'(got_idx.size()), 32'(exp_idx.size()));
    chk($sformatf("%s_done_count", name), 32'(done_count), 1);
    for (int i = 0; i < got_idx.size() && i < exp_idx.size(); i++) begin
      chk($sformatf("%s_idx%0d", name, i), got_idx[i], exp_idx[i]);
      chk($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
    end
  endtask

  initial begin
    bit found;
    bit seen5;

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    load_regs(16, 1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_halt", cpu_halt, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_rd_reg", rd_reg, 0);

    // Cycle-level vectors, regs[i] = 16*i+1 so nothing is skipped in either build.
    tbl[0]  = mk(1, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[1]  = mk(0, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[2]  = mk(0, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[3]  = mk(0, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[4]  = mk(0, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[5]  = mk(0, 0, 0,  1, 1, 1, 0,  5'd0, 32'h1);
    tbl[6]  = mk(0, 0, 0,  1, 1, 1, 0,  5'd0, 32'h1);
    tbl[7]  = mk(0, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[8]  = mk(0, 0, 1,  1, 1, 1, 0,  5'd1, 32'h11);
    tbl[9]  = mk(0, 1, 1,  0, 0, 0, 0,  5'd0, 32'h0);
    tbl[10] = mk(1, 1, 1,  0, 0, 0, 0,  5'd0, 32'h0);
    tbl[11] = mk(0, 0, 1,  0, 0, 0, 0,  5'd0, 32'h0);
    tbl[12] = mk(1, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[13] = mk(1, 0, 1,  1, 1, 0, 0,  5'd0, 32'h0);
    tbl[14] = mk(0, 1, 1,  0, 0, 0, 0,  5'd0, 32'h0);
    for (int k = 0; k < 15; k++) begin
      start = tbl[k].start; abort = tbl[k].abort; out_ready = tbl[k].ready;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", k), busy, tbl[k].busy);
      chk($sformatf("vec%0d_halt", k), cpu_halt, tbl[k].halt);
      chk($sformatf("vec%0d_valid", k), out_valid, tbl[k].valid);
      chk($sformatf("vec%0d_done", k), done, tbl[k].done);
      if (tbl[k].valid) begin
        chk($sformatf("vec%0d_idx", k), out_idx, tbl[k].idx);
        chk($sformatf("vec%0d_data", k), out_data, tbl[k].data);
      end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full dump at full speed.
    load_regs(16, 0);
    run_dump("full", 0, 0, 0);
    compare_dump("full");
`ifndef REG_DUMP_SKIP_ZERO_EN
    chk("full_first_valid_cyc", 32'(first_valid_cyc), 6);
    chk("full_done_cyc", 32'(done_cyc), 4 + 2 * 32 + 1);
`endif

    // Random backpressure, random contents, start pulses while busy.
    for (int i = 0; i < 32; i++) regs[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    run_dump("rand", 1, 1, 0);
    compare_dump("rand");

    // Writeback lands during DRAIN.
    load_regs(16, 1);
    regs[5] = 32'd0;
    run_dump("wb", 1, 0, 1);
    compare_dump("wb");
    seen5 = 0;
    for (int i = 0; i < got_idx.size(); i++) begin
      if (got_idx[i] == 5'd5) begin
        seen5 = 1;
        chk("wb_idx5_data", got_data[i], 32'hDEADBEEF);
      end
    end
    chk("wb_idx5_seen", 32'(seen5), 1);

    // Abort while presenting idx 10, then restart from idx 0.
    load_regs(16, 1);
    out_ready = 1'b1;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (out_valid && out_idx == 5'd10) found = 1;
    end
    chk("abort_reach_idx10", 32'(found), 1);
    out_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_halt", cpu_halt, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    @(posedge clk);
    #1;
    chk("abort_done_after", done, 0);
    run_dump("restart", 0, 0, 0);
    compare_dump("restart");
    if (got_idx.size() > 0) chk("restart_first_idx", got_idx[0], 0);

    // Reset in the middle of a dump clears the captured word.
    out_ready = 1'b1;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (out_valid && out_idx == 5'd3) found = 1;
    end
    chk("rstmid_reach", 32'(found), 1);
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstmid_data", out_data, 0);
    chk("rstmid_idx", out_idx, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_halt", cpu_halt, 0);
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_rd_reg", rd_reg, 0);

    // Sparse contents: only regs 3 and 31 nonzero.
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[3] = 32'h0000_0033;
    regs[31] = 32'hF000_0001;
    run_dump("sparse", 1, 0, 0);
    compare_dump("sparse");
`ifdef REG_DUMP_SKIP_ZERO_EN
    chk("sparse_count", 32'(got_idx.size()), 2);
`else
    chk("sparse_count", 32'(got_idx.size()), 32);
`endif

    // All zero: done must still pulse.
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    run_dump("zero", 0, 0, 0);
    compare_dump("zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
